// File: rtl/spike_dec_pkg.sv
// ---------------------------------------------------------------------------
// spike_dec_pkg
// Shared definitions for the spike rate decoder slice.
//   dec_state_e : decoder FSM states (IDLE, RUN)
//   sat_max()   : all-ones value of a given bit width, i.e. the value a
//                 saturating counter of that width stops at
// ---------------------------------------------------------------------------
package spike_dec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_e;

    // A width of 32 shifts the one out entirely and the subtraction then
    // wraps to all ones, which is still the correct saturation value.
    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its maximum value instead of wrapping.
// Ports:
//   clk     : clock, all logic on posedge
//   rst     : synchronous active-high reset, clears the count
//   clr_i   : synchronous clear, takes priority over inc_i
//   inc_i   : increment request, ignored once the count is saturated
//   count_o : current count (W bits)
// ---------------------------------------------------------------------------
module sat_counter
    import spike_dec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] CNT_MAX = W'(sat_max(W));

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment; increment is dropped at the ceiling.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
// Counts spikes over a fixed window of WINDOW_LEN cycles and presents the
// count of the last completed window on a valid/ready result port.
// Optional inter-spike-interval measurement is built only when the macro
// ISI_MEASURE_EN is defined; otherwise isi/isi_valid are tied to zero.
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   en         : decoder enable; low returns to idle and drops the window
//   spike_in   : spike level, each high cycle counts as one spike
//   rate       : saturated spike count of the last completed window
//   rate_valid : rate holds a result not yet accepted
//   rate_ready : consumer accepts rate when rate_valid && rate_ready
//   overrun    : sticky flag, a result was replaced before being accepted
//   isi        : cycles between the last two spikes (ISI_MEASURE_EN)
//   isi_valid  : one-cycle pulse when isi updates (ISI_MEASURE_EN)
// ---------------------------------------------------------------------------
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int WINDOW_LEN = 16,
    parameter int COUNT_W    = 8,
    parameter int ISI_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               spike_in,
    output logic [COUNT_W-1:0] rate,
    output logic               rate_valid,
    input  logic               rate_ready,
    output logic               overrun,
    output logic [ISI_W-1:0]   isi,
    output logic               isi_valid
);

    localparam int                 WIN_W    = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(sat_max(COUNT_W));

    dec_state_e         state_q;
    dec_state_e         state_d;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [WIN_W-1:0]   win_cnt_d;
    logic [COUNT_W-1:0] spike_cnt;
    logic [COUNT_W-1:0] rate_q;
    logic [COUNT_W-1:0] rate_d;
    logic               rate_valid_q;
    logic               rate_valid_d;
    logic               overrun_q;
    logic               overrun_d;

    logic running;
    logic keep_running;
    logic close;
    logic accept;

    assign running      = (state_q == RUN);
    assign keep_running = running && en;
    assign close        = running && (win_cnt_q == WIN_LAST);
    assign accept       = rate_valid_q && rate_ready;

    // Both states go to RUN when enabled and to IDLE otherwise, so the
    // next state is simply the enable.  The window position only advances
    // while we stay in RUN; anything else parks it at zero so the first RUN
    // cycle is window cycle 0.
    always_comb begin
        state_d   = en ? RUN : IDLE;
        win_cnt_d = '0;
        if (keep_running && !close) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
        end
    end

    // Spike count restarts at every close and whenever we are not going to
    // be in RUN next cycle, which discards a partial window.
    sat_counter #(
        .W (COUNT_W)
    ) u_spike_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (!keep_running || close),
        .inc_i   (spike_in),
        .count_o (spike_cnt)
    );

    // The closing cycle's own spike is folded into the result here since
    // the counter has not registered it yet.  A close always wins over an
    // accept; a close onto an unaccepted result raises the sticky overrun.
    always_comb begin
        rate_d       = rate_q;
        rate_valid_d = rate_valid_q;
        overrun_d    = overrun_q;
        if (close) begin
            rate_d       = (spike_in && (spike_cnt != CNT_MAX)) ? spike_cnt + COUNT_W'(1) : spike_cnt;
            rate_valid_d = 1'b1;
            if (rate_valid_q && !rate_ready) begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            rate_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            win_cnt_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign overrun    = overrun_q;

`ifdef ISI_MEASURE_EN

    localparam logic [ISI_W-1:0] ISI_MAX = ISI_W'(sat_max(ISI_W));

    logic [ISI_W-1:0] gap;
    logic [ISI_W-1:0] isi_q;
    logic [ISI_W-1:0] isi_d;
    logic             isi_valid_q;
    logic             isi_valid_d;
    logic             armed_q;
    logic             armed_d;

    // Gap restarts on every spike so it holds (distance - 1) when the next
    // spike arrives; it is held at zero outside RUN.
    sat_counter #(
        .W (ISI_W)
    ) u_gap_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (!keep_running || spike_in),
        .inc_i   (1'b1),
        .count_o (gap)
    );

    // The first spike after entering RUN only arms; each later spike
    // reports the distance to the previous one.  Leaving RUN disarms.
    always_comb begin
        isi_d       = isi_q;
        isi_valid_d = 1'b0;
        armed_d     = keep_running && (armed_q || spike_in);
        if (running && spike_in && armed_q) begin
            isi_d       = (gap != ISI_MAX) ? gap + ISI_W'(1) : gap;
            isi_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isi_q       <= '0;
            isi_valid_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            isi_q       <= isi_d;
            isi_valid_q <= isi_valid_d;
            armed_q     <= armed_d;
        end
    end

    assign isi       = isi_q;
    assign isi_valid = isi_valid_q;

`else

    assign isi       = '0;
    assign isi_valid = 1'b0;

`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_decoder
// Directed bench for spike_rate_decoder.  A window/ISI model written in terms
// of "cycles since entering RUN" predicts every output each cycle, and a
// handful of literal expectations pin down the headline scenarios.  A second
// instance with a 512-cycle window covers count saturation.
// ---------------------------------------------------------------------------
module tb_spike_rate_decoder;

    localparam int WL   = 16;
    localparam int CW   = 8;
    localparam int IW   = 8;
    localparam int WL2  = 512;
    localparam int CMAX = 255;
    localparam int IMAX = 255;
`ifdef ISI_MEASURE_EN
    localparam int ISI_ON = 1;
`else
    localparam int ISI_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          spike_in;
    logic          rate_ready;
    logic [CW-1:0] rate;
    logic          rate_valid;
    logic          overrun;
    logic [IW-1:0] isi;
    logic          isi_valid;

    logic          en2;
    logic          spike2;
    logic          ready2;
    logic [CW-1:0] rate2;
    logic          rate_valid2;
    logic          overrun2;
    logic [IW-1:0] isi2;
    logic          isi_valid2;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    // Model state
    bit mRunning;
    int mRunIdx;
    int mSpikes;
    int mLastSpike;
    int mRate;
    int mValid;
    int mOverrun;
    int mIsi;
    int mIsiValid;

    spike_rate_decoder #(.WINDOW_LEN(WL), .COUNT_W(CW), .ISI_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun),
        .isi        (isi),
        .isi_valid  (isi_valid)
    );

    spike_rate_decoder #(.WINDOW_LEN(WL2), .COUNT_W(CW), .ISI_W(IW)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .en         (en2),
        .spike_in   (spike2),
        .rate       (rate2),
        .rate_valid (rate_valid2),
        .rate_ready (ready2),
        .overrun    (overrun2),
        .isi        (isi2),
        .isi_valid  (isi_valid2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic s, input logic rd);
        @(negedge clk);
        #1;
        rst        = r;
        en         = e;
        spike_in   = s;
        rate_ready = rd;
    endtask

    // Behavioural model: window position is just the RUN-cycle index modulo
    // the window length; the count is kept exact and clipped on close, and
    // the interval is the distance between recorded spike indices.
    always @(posedge clk) begin
        int cnt;
        if (rst) begin
            mRunning   = 1'b0;
            mRunIdx    = 0;
            mSpikes    = 0;
            mLastSpike = -1;
            mRate      = 0;
            mValid     = 0;
            mOverrun   = 0;
            mIsi       = 0;
            mIsiValid  = 0;
        end else begin
            mIsiValid = 0;
            if (mRunning) begin
                cnt = mSpikes + int'(spike_in);
                if ((mRunIdx % WL) == WL - 1) begin
                    if (mValid == 1 && !rate_ready) mOverrun = 1;
                    mRate   = (cnt > CMAX) ? CMAX : cnt;
                    mValid  = 1;
                    mSpikes = 0;
                end else begin
                    mSpikes = cnt;
                    if (mValid == 1 && rate_ready) mValid = 0;
                end
                if (ISI_ON == 1 && spike_in) begin
                    if (mLastSpike >= 0) begin
                        mIsi      = (mRunIdx - mLastSpike > IMAX) ? IMAX : mRunIdx - mLastSpike;
                        mIsiValid = 1;
                    end
                    mLastSpike = mRunIdx;
                end
                if (en) begin
                    mRunIdx++;
                end else begin
                    mRunning   = 1'b0;
                    mSpikes    = 0;
                    mLastSpike = -1;
                end
            end else begin
                if (mValid == 1 && rate_ready) mValid = 0;
                if (en) begin
                    mRunning   = 1'b1;
                    mRunIdx    = 0;
                    mSpikes    = 0;
                    mLastSpike = -1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model rate", rate, mRate);
            checkOutput("model rate_valid", rate_valid, mValid);
            checkOutput("model overrun", overrun, mOverrun);
            checkOutput("model isi", isi, mIsi);
            checkOutput("model isi_valid", isi_valid, mIsiValid);
        end
    end

    initial begin
        int foundAt;
        bit found;

        rst = 1'b1; en = 1'b0; spike_in = 1'b0; rate_ready = 1'b0;
        en2 = 1'b0; spike2 = 1'b0; ready2 = 1'b0;
        repeat (3) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkEn = 1'b1;
        checkOutput("init rate", rate, 0);
        checkOutput("init rate_valid", rate_valid, 0);
        checkOutput("init overrun", overrun, 0);

        // Saturation on the long-window instance: constant spikes
        en2 = 1'b1; spike2 = 1'b1; ready2 = 1'b1;
        found = 1'b0; foundAt = -1;
        for (int c = 0; c < 600; c++) begin
            applyStimulus(0, 0, 0, 0);
            if (rate_valid2 === 1'b1) begin
                found = 1'b1; foundAt = c;
                break;
            end
        end
        checkOutput("sat result seen", found, 1);
        checkOutput("sat result cycle", foundAt, WL2);
        checkOutput("sat rate", rate2, 255);
        checkOutput("sat overrun", overrun2, 0);
        checkOutput("sat isi", isi2, ISI_ON == 1 ? 1 : 0);
        checkOutput("sat isi_valid", isi_valid2, ISI_ON == 1 ? 1 : 0);
        en2 = 1'b0; spike2 = 1'b0;

        // Spike every 4th cycle, always ready
        applyStimulus(0, 1, 0, 1);
        for (int c = 0; c < 34; c++) begin
            applyStimulus(0, 1, (c % 4) == 0, 1);
            if (c == 15) checkOutput("every4 valid c15", rate_valid, 0);
            if (c == 16) begin
                checkOutput("every4 valid c16", rate_valid, 1);
                checkOutput("every4 rate c16", rate, 4);
            end
            if (c == 17) checkOutput("every4 valid c17", rate_valid, 0);
            if (c == 32) begin
                checkOutput("every4 valid c32", rate_valid, 1);
                checkOutput("every4 rate c32", rate, 4);
            end
        end

        // Two closes without ready: 3 then 5 spikes
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int c = 0; c < 35; c++) begin
            applyStimulus(0, 1, (c < 3) || (c >= 16 && c < 21), c >= 33);
            if (c == 16) begin
                checkOutput("hold rate c16", rate, 3);
                checkOutput("hold valid c16", rate_valid, 1);
                checkOutput("hold overrun c16", overrun, 0);
            end
            if (c == 32) begin
                checkOutput("hold rate c32", rate, 5);
                checkOutput("hold valid c32", rate_valid, 1);
                checkOutput("hold overrun c32", overrun, 1);
            end
            if (c == 34) begin
                checkOutput("hold valid c34", rate_valid, 0);
                checkOutput("hold overrun c34", overrun, 1);
                checkOutput("hold rate c34", rate, 5);
            end
        end

        // Enable dropped mid-window, then a fresh window
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1);
        for (int c = 0; c < 9; c++) begin
            applyStimulus(0, 1, (c == 2) || (c == 5), 1);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1'b1, 1);
            checkOutput("partial no valid", rate_valid, 0);
        end
        applyStimulus(0, 1, 0, 1);
        for (int c = 0; c < 18; c++) begin
            applyStimulus(0, 1, (c == 1) || (c == 3) || (c == 7), 1);
            if (c == 15) checkOutput("fresh valid c15", rate_valid, 0);
            if (c == 16) begin
                checkOutput("fresh valid c16", rate_valid, 1);
                checkOutput("fresh rate c16", rate, 3);
            end
        end

        // Inter-spike intervals: spikes at RUN cycles 3, 10, 11
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int c = 0; c < 18; c++) begin
            applyStimulus(0, 1, (c == 3) || (c == 10) || (c == 11), 0);
            if (c == 4) checkOutput("isi no pulse c4", isi_valid, 0);
            if (c == 11) begin
                checkOutput("isi pulse c11", isi_valid, ISI_ON);
                checkOutput("isi value c11", isi, ISI_ON == 1 ? 7 : 0);
            end
            if (c == 12) begin
                checkOutput("isi pulse c12", isi_valid, ISI_ON);
                checkOutput("isi value c12", isi, ISI_ON == 1 ? 1 : 0);
            end
            if (c == 13) checkOutput("isi no pulse c13", isi_valid, 0);
            if (c == 16) checkOutput("isi-run rate c16", rate, 3);
        end
        checkOutput("pending before reset", rate_valid, 1);

        // Reset mid-run with a result pending
        repeat (3) applyStimulus(1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("post-reset rate", rate, 0);
        checkOutput("post-reset valid", rate_valid, 0);
        checkOutput("post-reset overrun", overrun, 0);
        checkOutput("post-reset isi_valid", isi_valid, 0);
        checkOutput("post-reset isi", isi, 0);
        repeat (3) applyStimulus(0, 0, 0, 1);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
